flasher_arbiter: RTL and testbench

- Shares one bound_flasher LED bank between NREQ independent requesters.
- Grants requesters round-robin and issues the start flick for the granted requester.
- Tracks the flasher's led bus to detect the start and end of each run.
- Sits between the request sources and bound_flasher; drives its flick input and observes its led output.

---
 rtl/flasher_arb_pkg.sv | 19 +
 rtl/flasher_arbiter_if.sv | 28 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/flasher_arbiter.sv | 134 +++++++++++++
 tb/tb_flasher_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/flasher_arb_pkg.sv
// Shared types and constants for the flasher arbiter slice.
package flasher_arb_pkg;

    localparam int unsigned LED_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_RUN,
        ST_GAP
    } arb_state_e;

    // Width of a saturating counter able to hold run_timeout.
    function automatic int unsigned cnt_width(input int unsigned run_timeout);
        return (run_timeout < 1) ? 1 : $clog2(run_timeout + 1);
    endfunction

endpackage

// File: rtl/flasher_arbiter_if.sv
// Request/grant and LED-bank signals between requesters, flasher and arbiter.
interface flasher_arbiter_if
    import flasher_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
);

    logic [NREQ-1:0]  req;
    logic [LED_W-1:0] led;
    logic             flick;
    logic [NREQ-1:0]  gnt;
    logic             busy;
    logic             done;
    logic             err;

    // Environment side: requesters plus the flasher's LED bus.
    modport master (
        output req, led,
        input  flick, gnt, busy, done, err
    );

    // Arbiter side.
    modport slave (
        input  req, led,
        output flick, gnt, busy, done, err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: combinational one-hot selection from a rotating pointer.
module rr_arbiter
    import flasher_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic            valid_c_o,
    output logic [NREQ-1:0] pick_c_o
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] sel_c;
    logic             found_c;
    int unsigned      idx_c;

    // First requesting index at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        found_c  = 1'b0;
        sel_c    = '0;
        pick_c_o = '0;
        idx_c    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_c = 32'(ptr_q) + k;
            if (idx_c >= NREQ) begin
                idx_c = idx_c - NREQ;
            end
            if (!found_c && req_i[PTR_W'(idx_c)]) begin
                found_c                 = 1'b1;
                sel_c                   = PTR_W'(idx_c);
                pick_c_o[PTR_W'(idx_c)] = 1'b1;
            end
        end
        valid_c_o = found_c;
    end

    // Pointer moves to just past the winner, modulo NREQ.
    always_comb begin
        ptr_d = (sel_c == PTR_W'(NREQ - 1)) ? '0 : sel_c + PTR_W'(1);
    end

    // Pointer advances only when the pick is actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept_i && found_c) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/flasher_arbiter.sv
// Shares one flasher LED bank among NREQ requesters: grant, flick, track run.
module flasher_arbiter
    import flasher_arb_pkg::*;
#(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned FLICK_CYCLES  = 1,
    parameter int unsigned START_TIMEOUT = 15,
    parameter int unsigned RUN_TIMEOUT   = 255,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic              clk,
    input  logic              rst,
    flasher_arbiter_if.slave  arb_if
);

    localparam int unsigned CNT_W = cnt_width(RUN_TIMEOUT);

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [NREQ-1:0]  gnt_q;
    logic             flick_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [NREQ-1:0]  pick_oh;
    logic             pick_valid;
    logic             accept;
    logic             led_nz;

    assign accept  = (state_q == ST_IDLE);
    assign led_nz  = |arb_if.led;
    // Counter saturates at all-ones rather than wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (arb_if.req),
        .accept_i  (accept),
        .valid_c_o (pick_valid),
        .pick_c_o  (pick_oh)
    );

    // Arbitration FSM with registered grant, flick and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            flick_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (pick_valid) begin
                        gnt_q   <= pick_oh;
                        flick_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cnt_inc >= CNT_W'(FLICK_CYCLES)) begin
                        flick_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_START;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_WAIT_START: begin
                    if (led_nz) begin
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end else if (cnt_inc >= CNT_W'(START_TIMEOUT)) begin
                        err_q   <= 1'b1;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (!led_nz) begin
                        done_q  <= 1'b1;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else if (cnt_inc >= CNT_W'(RUN_TIMEOUT)) begin
                        err_q   <= 1'b1;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_GAP: begin
                    if (cnt_inc >= CNT_W'(GAP_CYCLES)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    gnt_q   <= '0;
                    flick_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign arb_if.flick = flick_q;
    assign arb_if.gnt   = gnt_q;
    assign arb_if.busy  = busy_q;
    assign arb_if.done  = done_q;
    assign arb_if.err   = err_q;

endmodule

// File: tb/tb_flasher_arbiter.sv
// Scoreboard bench for flasher_arbiter with a behavioural LED-bank stand-in.
module tb_flasher_arbiter;

    localparam int NREQ          = 4;
    localparam int START_TIMEOUT = 15;
    localparam int RUN_TIMEOUT   = 255;
    localparam int GAP_CYCLES    = 4;
    localparam int START_DLY     = 3;
    localparam int RUN_LEN       = 6;

    typedef enum int {LM_DISC, LM_NORMAL, LM_STUCK} led_mode_e;

    logic      clk;
    logic      rst;
    led_mode_e led_mode;
    logic      flick_prev;
    int        ph;

    int n_tests;
    int n_fail;
    int ref_ptr;
    logic [NREQ-1:0] exp_q[$];

    flasher_arbiter_if #(.NREQ(NREQ)) bus ();

    flasher_arbiter #(
        .NREQ          (NREQ),
        .FLICK_CYCLES  (1),
        .START_TIMEOUT (START_TIMEOUT),
        .RUN_TIMEOUT   (RUN_TIMEOUT),
        .GAP_CYCLES    (GAP_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LED bank stand-in: lights a short walking pattern after each flick.
    always @(posedge clk) begin
        if (rst) begin
            flick_prev <= 1'b0;
            ph         <= 0;
            bus.led    <= 16'h0000;
        end else begin
            flick_prev <= bus.flick;
            if (flick_prev && !bus.flick) ph <= 1;
            else if (ph != 0) ph <= (led_mode == LM_NORMAL && ph >= START_DLY + RUN_LEN) ? 0 : ph + 1;
            case (led_mode)
                LM_NORMAL: bus.led <= (ph >= START_DLY && ph < START_DLY + RUN_LEN) ?
                                      (16'h0001 << (ph - START_DLY)) : 16'h0000;
                LM_STUCK:  bus.led <= (ph >= START_DLY) ? 16'h0001 : 16'h0000;
                default:   bus.led <= 16'h0000;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin pick; pushes the expected grant.
    task automatic ref_push(input logic [NREQ-1:0] r);
        logic [NREQ-1:0] oh;
        int idx;
        int p;
        oh = '0;
        p  = ref_ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (oh == '0 && r[idx]) begin
                oh[idx] = 1'b1;
                ref_ptr = (idx + 1) % NREQ;
            end
        end
        exp_q.push_back(oh);
    endtask

    task automatic pop_exp(output logic [NREQ-1:0] e);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        step();
        rst     = 1'b0;
        ref_ptr = 0;
        exp_q.delete();
    endtask

    task automatic wait_flick(input int bound, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            cyc++;
            if (bus.flick === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_end(input int bound, input logic [NREQ-1:0] hold,
                            output bit got, output int cyc, output bit unstable);
        got      = 1'b0;
        cyc      = 0;
        unstable = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            cyc++;
            if (bus.done === 1'b1 || bus.err === 1'b1) got = 1'b1;
            else if (bus.gnt !== hold) unstable = 1'b1;
        end
    endtask

    task automatic wait_idle(input int bound, output bit got, output int cyc, output int pulses);
        got    = 1'b0;
        cyc    = 0;
        pulses = 0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            cyc++;
            if (bus.done === 1'b1 || bus.err === 1'b1) pulses++;
            if (bus.busy === 1'b0) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = '0; led_mode = LM_DISC;
        step(); step();
        n_tests++; if (bus.flick !== 1'b0) begin n_fail++; $display("FAIL reset_flick got %b exp 0", bus.flick); end
        n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.err); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit got, unstable; int cyc, pulses; logic [NREQ-1:0] e;
        do_reset(); led_mode = LM_NORMAL;
        bus.req = 4'b0001; ref_push(4'b0001);
        wait_flick(4, got, cyc); pop_exp(e);
        n_tests++; if (!got || cyc != 1) begin n_fail++; $display("FAIL single_latency got %0d cycles (seen %b) exp 1", cyc, got); end
        n_tests++; if (bus.gnt !== e) begin n_fail++; $display("FAIL single_gnt got %b exp %b", bus.gnt, e); end
        bus.req = '0;
        step();
        n_tests++; if (bus.flick !== 1'b0) begin n_fail++; $display("FAIL single_flick_width got %b exp 0", bus.flick); end
        wait_end(64, e, got, cyc, unstable);
        n_tests++; if (!got || bus.done !== 1'b1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL single_done got done=%b err=%b exp done=1 err=0", bus.done, bus.err); end
        n_tests++; if (unstable) begin n_fail++; $display("FAIL single_gnt_stable got changing gnt exp %b held", e); end
        n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_clear got %b exp 0000", bus.gnt); end
        wait_idle(16, got, cyc, pulses);
        n_tests++; if (!got || cyc != GAP_CYCLES) begin n_fail++; $display("FAIL single_gap got %0d exp %0d", cyc, GAP_CYCLES); end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL single_done_once got %0d extra pulses exp 0", pulses); end
    endtask

    task automatic test_round_robin();
        bit got, unstable; int cyc, pulses; logic [NREQ-1:0] e;
        do_reset(); led_mode = LM_NORMAL;
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) ref_push(4'b1111);
        for (int r = 0; r < 4; r++) begin
            wait_flick(32, got, cyc); pop_exp(e);
            n_tests++; if (!got || bus.gnt !== e) begin n_fail++; $display("FAIL rr_gnt run %0d got %b exp %b", r, bus.gnt, e); end
            if (r > 0) begin
                n_tests++; if (cyc != GAP_CYCLES + 1) begin n_fail++; $display("FAIL rr_gap_spacing run %0d got %0d exp %0d", r, cyc, GAP_CYCLES + 1); end
            end
            if (r == 3) bus.req = '0;
            wait_end(64, e, got, cyc, unstable);
            n_tests++; if (!got || bus.done !== 1'b1 || unstable) begin n_fail++; $display("FAIL rr_run_end run %0d got done=%b unstable=%b exp done=1 stable", r, bus.done, unstable); end
        end
        wait_idle(16, got, cyc, pulses);
    endtask

    task automatic test_priority();
        bit got, unstable; int cyc, pulses; logic [NREQ-1:0] e;
        do_reset(); led_mode = LM_NORMAL;
        bus.req = 4'b0001; ref_push(4'b0001);
        wait_flick(4, got, cyc); pop_exp(e);
        bus.req = '0;
        wait_end(64, e, got, cyc, unstable);
        wait_idle(16, got, cyc, pulses);
        bus.req = 4'b0110; ref_push(4'b0110); ref_push(4'b0100);
        wait_flick(4, got, cyc); pop_exp(e);
        n_tests++; if (!got || bus.gnt !== e) begin n_fail++; $display("FAIL prio_first got %b exp %b", bus.gnt, e); end
        bus.req = 4'b0100;
        wait_end(64, e, got, cyc, unstable);
        wait_flick(32, got, cyc); pop_exp(e);
        n_tests++; if (!got || bus.gnt !== e) begin n_fail++; $display("FAIL prio_second got %b exp %b", bus.gnt, e); end
        bus.req = '0;
        wait_end(64, e, got, cyc, unstable);
        wait_idle(16, got, cyc, pulses);
    endtask

    task automatic test_start_timeout();
        bit got, unstable; int cyc, pulses; logic [NREQ-1:0] e;
        do_reset(); led_mode = LM_DISC;
        bus.req = 4'b0001; ref_push(4'b0001);
        wait_flick(4, got, cyc); pop_exp(e);
        n_tests++; if (!got || bus.gnt !== e) begin n_fail++; $display("FAIL st_gnt got %b exp %b", bus.gnt, e); end
        bus.req = '0;
        step();
        wait_end(64, e, got, cyc, unstable);
        n_tests++; if (!got || cyc != START_TIMEOUT) begin n_fail++; $display("FAIL st_delay got %0d exp %0d", cyc, START_TIMEOUT); end
        n_tests++; if (bus.err !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL st_err got err=%b done=%b exp err=1 done=0", bus.err, bus.done); end
        n_tests++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL st_gap got gnt=%b busy=%b exp 0000/1", bus.gnt, bus.busy); end
        wait_idle(16, got, cyc, pulses);
        n_tests++; if (!got || pulses != 0) begin n_fail++; $display("FAIL st_idle got idle=%b pulses=%0d exp 1/0", got, pulses); end
    endtask

    task automatic test_run_timeout();
        bit got, unstable; int cyc, pulses; logic [NREQ-1:0] e;
        do_reset(); led_mode = LM_STUCK;
        bus.req = 4'b0001; ref_push(4'b0001);
        wait_flick(4, got, cyc); pop_exp(e);
        bus.req = '0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin step(); if (bus.led !== 16'h0000) got = 1'b1; end
        n_tests++; if (!got) begin n_fail++; $display("FAIL rt_led_start got led=%h exp nonzero", bus.led); end
        wait_end(400, e, got, cyc, unstable);
        n_tests++; if (!got || cyc != RUN_TIMEOUT + 1) begin n_fail++; $display("FAIL rt_delay got %0d exp %0d", cyc, RUN_TIMEOUT + 1); end
        n_tests++; if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL rt_err got err=%b done=%b gnt=%b exp 1/0/0000", bus.err, bus.done, bus.gnt); end
        n_tests++; if (unstable) begin n_fail++; $display("FAIL rt_gnt_stable got changing gnt exp %b held", e); end
        led_mode = LM_DISC;
        wait_idle(16, got, cyc, pulses);
    endtask

    task automatic test_reset_mid_run();
        bit got, unstable; int cyc, pulses; logic [NREQ-1:0] e;
        for (int ph2 = 0; ph2 < 2; ph2++) begin
            do_reset(); led_mode = LM_STUCK;
            bus.req = (ph2 == 0) ? 4'b0001 : 4'b0010;
            ref_push(bus.req);
            wait_flick(4, got, cyc); pop_exp(e);
            bus.req = (ph2 == 0) ? 4'b1000 : 4'b0000;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin step(); if (bus.led !== 16'h0000) got = 1'b1; end
            step(); step(); step();
            rst = 1'b1;
            step();
            n_tests++; if (bus.gnt !== 4'b0000 || bus.flick !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gnt got gnt=%b flick=%b exp 0000/0", bus.gnt, bus.flick); end
            n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_status got busy=%b done=%b err=%b exp 0/0/0", bus.busy, bus.done, bus.err); end
            rst = 1'b0; ref_ptr = 0; exp_q.delete();
            led_mode = LM_NORMAL;
            if (ph2 == 1) bus.req = 4'b0101;
            ref_push(bus.req);
            wait_flick(4, got, cyc); pop_exp(e);
            n_tests++; if (!got || cyc != 1 || bus.gnt !== e) begin n_fail++; $display("FAIL mid_rst_regrant phase %0d got gnt=%b after %0d exp %b after 1", ph2, bus.gnt, cyc, e); end
            bus.req = '0;
            wait_end(64, e, got, cyc, unstable);
            n_tests++; if (!got || bus.done !== 1'b1) begin n_fail++; $display("FAIL mid_rst_done phase %0d got done=%b exp 1", ph2, bus.done); end
            wait_idle(16, got, cyc, pulses);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        ref_ptr  = 0;
        rst      = 1'b1;
        bus.req  = '0;
        led_mode = LM_DISC;
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_start_timeout();
        test_run_timeout();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
